// File: rtl/vs_seq_pkg.sv
// Shared types and limits for the sequential flag-register blocks.
package vs_seq_pkg;

  typedef enum logic [1:0] {
    VS_CONFLICT_HOLD       = 2'd0,
    VS_CONFLICT_SET_WINS   = 2'd1,
    VS_CONFLICT_RESET_WINS = 2'd2,
    VS_CONFLICT_TOGGLE     = 2'd3
  } vs_conflict_mode_t;

  localparam int VS_SR_MAX_WIDTH = 64;

endpackage

// File: rtl/vs_sr_cell.sv
// Single-bit SR next-state resolver; purely combinational.
module vs_sr_cell
  import vs_seq_pkg::*;
#(
  parameter vs_conflict_mode_t CONFLICT_MODE = VS_CONFLICT_HOLD
) (
  input  logic q,
  input  logic set,
  input  logic reset,
  output logic q_nxt
);

  always_comb begin
    q_nxt = q;
    case ({set, reset})
      2'b10: q_nxt = 1'b1;
      2'b01: q_nxt = 1'b0;
      2'b11: begin
        case (CONFLICT_MODE)
          VS_CONFLICT_SET_WINS:   q_nxt = 1'b1;
          VS_CONFLICT_RESET_WINS: q_nxt = 1'b0;
          VS_CONFLICT_TOGGLE:     q_nxt = ~q;
          default:                q_nxt = q;
        endcase
      end
      default: q_nxt = q;
    endcase
  end

endmodule

// File: rtl/vs_sr_reg_bank.sv
// WIDTH-bit bank of edge-triggered SR flags with load, sync clear, edge pulses
// and sticky conflict flags. Single-cycle update, no backpressure.
module vs_sr_reg_bank
  import vs_seq_pkg::*;
#(
  parameter int                WIDTH         = 8,
  parameter vs_conflict_mode_t CONFLICT_MODE = VS_CONFLICT_HOLD,
  parameter logic [WIDTH-1:0]  RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load_en,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] reset,
  input  logic [WIDTH-1:0] conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] conflict,
  output logic             any_q
);

  if (WIDTH < 1 || WIDTH > VS_SR_MAX_WIDTH) begin : g_bad_width
    $error("vs_sr_reg_bank: WIDTH %0d outside 1..%0d", WIDTH, VS_SR_MAX_WIDTH);
  end

  if (!(CONFLICT_MODE inside {VS_CONFLICT_HOLD, VS_CONFLICT_SET_WINS,
                              VS_CONFLICT_RESET_WINS, VS_CONFLICT_TOGGLE})) begin : g_bad_mode
    $error("vs_sr_reg_bank: illegal CONFLICT_MODE");
  end

  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] conflict_new;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    vs_sr_cell #(.CONFLICT_MODE(CONFLICT_MODE)) u_cell (
      .q     (q[i]),
      .set   (set[i]),
      .reset (reset[i]),
      .q_nxt (q_res[i])
    );
  end

  always_comb begin
    q_nxt = q_res;
    if (clear) begin
      q_nxt = '0;
    end else if (load_en) begin
      q_nxt = d;
    end
  end

  // Load suppresses conflict capture because set/reset are ignored that cycle.
  assign conflict_new = load_en ? '0 : (set & reset);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q        <= RESET_VALUE;
      rise     <= '0;
      fall     <= '0;
      conflict <= '0;
    end else if (clear) begin
      q        <= '0;
      rise     <= '0;
      fall     <= '0;
      conflict <= '0;
    end else begin
      q        <= q_nxt;
      rise     <= q_nxt & ~q;
      fall     <= ~q_nxt & q;
      conflict <= conflict_new | (conflict & ~conflict_clr);
    end
  end

  assign qbar  = ~q;
  assign any_q = |q;

endmodule

// File: tb/tb_vs_sr_reg_bank.sv
// Drives one bank per conflict mode in parallel and checks them against a bitwise reference model.
module tb_vs_sr_reg_bank;
  import vs_seq_pkg::*;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear, load_en;
  logic [7:0] d, set, reset, conflict_clr;

  logic [7:0] q_o [4];
  logic [7:0] qbar_o [4];
  logic [7:0] rise_o [4];
  logic [7:0] fall_o [4];
  logic [7:0] conf_o [4];
  logic       any_o [4];

  logic [7:0] mq [4];
  logic [7:0] mr [4];
  logic [7:0] mf [4];
  logic [7:0] mc [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    vs_sr_reg_bank #(
      .WIDTH         (8),
      .CONFLICT_MODE (vs_conflict_mode_t'(g)),
      .RESET_VALUE   (RV)
    ) u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (clear),
      .load_en      (load_en),
      .d            (d),
      .set          (set),
      .reset        (reset),
      .conflict_clr (conflict_clr),
      .q            (q_o[g]),
      .qbar         (qbar_o[g]),
      .rise         (rise_o[g]),
      .fall         (fall_o[g]),
      .conflict     (conf_o[g]),
      .any_q        (any_o[g])
    );
  end

  // Mode m: 0 hold, 1 set wins, 2 reset wins, 3 toggle.
  function automatic logic [7:0] model_next(int m, logic [7:0] cur);
    logic [7:0] both;
    logic [7:0] n;
    if (clear) return 8'h00;
    if (load_en) return d;
    both = set & reset;
    n = (cur | set) & ~reset;
    case (m)
      0: n = n | (both & cur);
      1: n = n | both;
      3: n = n | (both & ~cur);
      default: ;
    endcase
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = RV; mr[i] = 8'h00; mf[i] = 8'h00; mc[i] = 8'h00;
    end
  endtask

  task automatic idle_inputs();
    clear = 1'b0; load_en = 1'b0; d = 8'h00;
    set = 8'h00; reset = 8'h00; conflict_clr = 8'h00;
  endtask

  // Advance model and DUT one edge; returns 1 time unit after the edge.
  task automatic tick();
    logic [7:0] nq;
    for (int i = 0; i < 4; i++) begin
      nq = model_next(i, mq[i]);
      if (clear) begin
        mr[i] = 8'h00; mf[i] = 8'h00; mc[i] = 8'h00;
      end else begin
        mr[i] = nq & ~mq[i];
        mf[i] = ~nq & mq[i];
        mc[i] = (load_en ? 8'h00 : (set & reset)) | (mc[i] & ~conflict_clr);
      end
      mq[i] = nq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    #12;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_o[i] !== 8'hA5 || qbar_o[i] !== 8'h5A || rise_o[i] !== 8'h00 ||
          fall_o[i] !== 8'h00 || conf_o[i] !== 8'h00 || any_o[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state inst%0d q=%h qbar=%h rise=%h fall=%h conf=%h any=%b want A5 5A 00 00 00 1",
                 i, q_o[i], qbar_o[i], rise_o[i], fall_o[i], conf_o[i], any_o[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_o[i] !== 8'hA5 || rise_o[i] !== 8'h00 || fall_o[i] !== 8'h00) begin
          errors++;
          $display("FAIL reset_idle inst%0d cyc%0d q=%h rise=%h fall=%h want A5 00 00",
                   i, c, q_o[i], rise_o[i], fall_o[i]);
        end
      end
    end
  endtask

  task automatic test_set_reset();
    idle_inputs(); load_en = 1'b1; d = 8'h00;
    tick();
    idle_inputs(); set = 8'h0F;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_o[i] !== 8'h0F || rise_o[i] !== 8'h0F || qbar_o[i] !== 8'hF0) begin
        errors++;
        $display("FAIL set_pulse inst%0d q=%h rise=%h qbar=%h want 0F 0F F0", i, q_o[i], rise_o[i], qbar_o[i]);
      end
    end
    idle_inputs();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rise_o[i] !== 8'h00 || q_o[i] !== 8'h0F) begin
        errors++;
        $display("FAIL set_steady inst%0d q=%h rise=%h want 0F 00", i, q_o[i], rise_o[i]);
      end
    end
    reset = 8'h03;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_o[i] !== 8'h0C || fall_o[i] !== 8'h03 || rise_o[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_pulse inst%0d q=%h fall=%h rise=%h want 0C 03 00", i, q_o[i], fall_o[i], rise_o[i]);
      end
    end
  endtask

  task automatic test_conflict_modes();
    logic [7:0] want1 [4];
    logic [7:0] want2 [4];
    want1 = '{8'h01, 8'h03, 8'h00, 8'h02};
    want2 = '{8'h01, 8'h03, 8'h00, 8'h01};
    idle_inputs(); load_en = 1'b1; d = 8'h01;
    tick();
    idle_inputs(); set = 8'h03; reset = 8'h03;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_o[i] !== want1[i] || conf_o[i] !== 8'h03) begin
        errors++;
        $display("FAIL conflict_cyc1 inst%0d q=%h conf=%h want %h 03", i, q_o[i], conf_o[i], want1[i]);
      end
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_o[i] !== want2[i] || conf_o[i] !== 8'h03 || rise_o[i] !== mr[i] || fall_o[i] !== mf[i]) begin
        errors++;
        $display("FAIL conflict_cyc2 inst%0d q=%h conf=%h rise=%h fall=%h want %h 03 %h %h",
                 i, q_o[i], conf_o[i], rise_o[i], fall_o[i], want2[i], mr[i], mf[i]);
      end
    end
  endtask

  task automatic test_priority();
    idle_inputs(); load_en = 1'b1; d = 8'hF0;
    tick();
    d = 8'h3C; set = 8'hFF;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_o[i] !== 8'h3C || conf_o[i] !== 8'h03 || rise_o[i] !== 8'h0C || fall_o[i] !== 8'hC0) begin
        errors++;
        $display("FAIL load_prio inst%0d q=%h conf=%h rise=%h fall=%h want 3C 03 0C C0",
                 i, q_o[i], conf_o[i], rise_o[i], fall_o[i]);
      end
    end
    clear = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_o[i] !== 8'h00 || rise_o[i] !== 8'h00 || fall_o[i] !== 8'h00 ||
          conf_o[i] !== 8'h00 || any_o[i] !== 1'b0) begin
        errors++;
        $display("FAIL clear_prio inst%0d q=%h rise=%h fall=%h conf=%h any=%b want 00 00 00 00 0",
                 i, q_o[i], rise_o[i], fall_o[i], conf_o[i], any_o[i]);
      end
    end
  endtask

  task automatic test_conflict_race();
    idle_inputs(); set = 8'h01; reset = 8'h01;
    tick();
    conflict_clr = 8'h01;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (conf_o[i] !== 8'h01) begin
        errors++;
        $display("FAIL conflict_race inst%0d conf=%h want 01", i, conf_o[i]);
      end
    end
    idle_inputs(); conflict_clr = 8'h01;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (conf_o[i] !== 8'h00) begin
        errors++;
        $display("FAIL conflict_clr inst%0d conf=%h want 00", i, conf_o[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      clear        = ($urandom_range(0, 19) == 0);
      load_en      = ($urandom_range(0, 7) == 0);
      d            = 8'($urandom);
      set          = 8'($urandom) & 8'($urandom);
      reset        = 8'($urandom) & 8'($urandom);
      conflict_clr = 8'($urandom) & 8'($urandom) & 8'($urandom);
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_o[i] !== mq[i] || qbar_o[i] !== ~mq[i] || rise_o[i] !== mr[i] ||
            fall_o[i] !== mf[i] || conf_o[i] !== mc[i] || any_o[i] !== (mq[i] != 8'h00)) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d q=%h rise=%h fall=%h conf=%h any=%b want %h %h %h %h %b",
                   i, c, q_o[i], rise_o[i], fall_o[i], conf_o[i], any_o[i],
                   mq[i], mr[i], mf[i], mc[i], (mq[i] != 8'h00));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    idle_inputs(); clear = 1'b1;
    tick();
    idle_inputs(); set = 8'h80; reset = 8'h80;
    tick();
    idle_inputs(); set = 8'hFF;
    tick();
    checks++;
    if (rise_o[0] !== 8'hFF || conf_o[0] !== 8'h80) begin
      errors++;
      $display("FAIL async_pre rise=%h conf=%h want FF 80", rise_o[0], conf_o[0]);
    end
    idle_inputs();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_o[i] !== RV || rise_o[i] !== 8'h00 || fall_o[i] !== 8'h00 || conf_o[i] !== 8'h00) begin
        errors++;
        $display("FAIL async_reset inst%0d q=%h rise=%h fall=%h conf=%h want A5 00 00 00",
                 i, q_o[i], rise_o[i], fall_o[i], conf_o[i]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_set_reset();
    test_conflict_modes();
    test_priority();
    test_conflict_race();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vs_sr_reg_bank.md
Name: vs_sr_reg_bank

Overview:
- Parametrised, clocked successor to the single-bit SR and D latches: a WIDTH-bit bank of edge-triggered SR flip-flops.
- Adds selectable set/reset conflict resolution, parallel D-load, synchronous clear, per-bit rise/fall event pulses and sticky conflict flags.
- Used as a status/flag register: interrupt-pending bits, sticky error bits, handshake flags.
- Fully synchronous to one clock; no latches inferred.

Parameters:
- WIDTH, 8, number of flag bits; legal range 1..64.
- CONFLICT_MODE, VS_CONFLICT_HOLD, action when set[i] and reset[i] are both 1: HOLD keeps q[i]; SET_WINS gives q[i]=1; RESET_WINS gives q[i]=0; TOGGLE gives q[i]=~q[i].
- RESET_VALUE, '0, WIDTH-bit value loaded into q on asynchronous reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of q, conflict, rise and fall to 0.
- load_en  input  1  parallel load strobe.
- d  input  WIDTH  parallel load data.
- set  input  WIDTH  per-bit set request.
- reset  input  WIDTH  per-bit reset request.
- conflict_clr  input  WIDTH  per-bit clear of sticky conflict flag.
- q  output  WIDTH  registered flag state.
- qbar  output  WIDTH  always ~q; registered with q, never independently driven.
- rise  output  WIDTH  one-cycle pulse, bit i high in the first cycle q[i] reads 1 after being 0.
- fall  output  WIDTH  one-cycle pulse, bit i high in the first cycle q[i] reads 0 after being 1.
- conflict  output  WIDTH  sticky flag; set[i]&reset[i] was seen.
- any_q  output  1  combinational OR-reduce of q.

Behaviour:
- Reset values: asynchronous, active-low. While reset_n=0: q=RESET_VALUE, qbar=~RESET_VALUE, rise=0, fall=0, conflict=0. Release is synchronous to the next clk edge.
- Next-state priority per clock edge, highest first:
  1. clear: q_nxt = 0.
  2. load_en: q_nxt = d; set and reset are ignored that cycle.
  3. Per-bit resolution:
     - set=1, reset=0: q_nxt=1.
     - set=0, reset=1: q_nxt=0.
     - set=0, reset=0: q_nxt=q.
     - set=1, reset=1: per CONFLICT_MODE.
- Latency: q updates at the edge that samples the request; no pipelining.
- Edge pulses: rise <= q_nxt & ~q and fall <= ~q_nxt & q are registered with q, so a pulse coincides with the new q value. Steady state gives 0.
  - The clear edge also forces rise=fall=0, so no fall pulse is produced by clear.
  - Load produces normal rise/fall pulses.
- TOGGLE with sustained set&reset: q alternates every cycle, and rise/fall alternate with it.
- Conflict flags:
  - conflict[i] <= 1 when set[i]&reset[i] is sampled and neither clear nor load_en is active, in every CONFLICT_MODE.
  - Otherwise conflict_clr[i] clears it.
  - A new conflict in the same cycle as conflict_clr[i] wins, so the flag stays 1.
  - clear zeroes all conflict bits.
- Width rules: all vectors are WIDTH bits; no arithmetic.
- Out-of-range parameters: elaboration error via $error for WIDTH<1, WIDTH>64 or an illegal CONFLICT_MODE.
- Mid-operation reset: asserting reset_n=0 overrides everything immediately. No pending pulse survives.

Decomposition:
- Package vs_seq_pkg:
  - enum vs_conflict_mode_t with values VS_CONFLICT_HOLD, VS_CONFLICT_SET_WINS, VS_CONFLICT_RESET_WINS, VS_CONFLICT_TOGGLE.
  - constant VS_SR_MAX_WIDTH = 64.
- Sub-module vs_sr_cell:
  - Single-bit combinational next-state resolver: inputs q, set, reset; output q_nxt, parameterised by CONFLICT_MODE.
  - Instantiated WIDTH times by generate.
  - Registers, clear/load priority and conflict/edge logic stay in the top.

Test Plan:
- Reset: hold reset_n=0 with RESET_VALUE=8'hA5 → q=A5, qbar=5A, rise=fall=conflict=00. Release and idle 3 cycles → q stays A5, no pulses.
- Set/reset: from q=00, set=8'h0F for 1 cycle → q=0F and rise=0F that cycle; next cycle rise=00. Then reset=8'h03 → q=0C, fall=03.
- Conflict modes: per mode, q=8'h01 and set=reset=8'h03 for 2 cycles:
  - HOLD → q stays 01.
  - SET_WINS → q=03.
  - RESET_WINS → q=00.
  - TOGGLE → q=02 then 01.
  - All modes → conflict=03.
- Priority: q=F0, load_en=1, d=3C, set=FF, clear=0 → q=3C, conflict unchanged. Then clear=1 with load_en=1 → q=00, rise=fall=00.
- Conflict clear race: conflict=01, conflict_clr=01 with set=reset=01 in the same cycle → conflict stays 01. Next cycle conflict_clr=01 alone → 00.
- Async reset mid-pulse: reset_n low between edges in the cycle rise=FF → q, rise and conflict go to reset values immediately, without a clock edge.
